nios2_mult_cell_pipe: RTL and testbench

Parametrised, pipelined integer multiplier cell for the Nios II custom datapath. It succeeds the fixed 32-bit low-word-only multiply cell with configurable operand width, all four Nios II multiply flavours (MUL, MULXUU, MULXSU, MULXSS), valid/ready flow control, a pipeline kill for branch/exception flushes, and a passthrough tag. It sits between the A-stage operand latches and the writeback mux.

---
 rtl/nios2_mult_cell_pipe.sv | 122 ++++++++++++
 tb/tb_nios2_mult_cell_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_mult_cell_pipe.sv
// Two-stage pipelined multiplier cell for the Nios II custom datapath: half-word partial
// products in S1, recombination plus signed high-word correction in S2, valid/ready with kill.
module nios2_mult_cell_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int unsigned H  = DATA_W / 2;
    localparam int unsigned PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,
        MODE_MULXUU = 2'b01,
        MODE_MULXSU = 2'b10,
        MODE_MULXSS = 2'b11
    } mode_e;

    logic              en;
    mode_e             in_mode_e;
    logic [H-1:0]      a0, a1, b0, b1;
    logic [DATA_W-1:0] p00_d, p01_d, p10_d, p11_d;
    logic [DATA_W-1:0] ca_d, cb_d;

    logic              v1;
    mode_e             mode1;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] p00, p01, p10, p11;
    logic [DATA_W-1:0] ca, cb;

    logic [DATA_W:0]   mid_sum;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] result_d;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en & ~reset;
    assign in_mode_e = mode_e'(in_mode);

    assign {a1, a0} = in_src1;
    assign {b1, b0} = in_src2;

    assign p00_d = {{H{1'b0}}, a0} * {{H{1'b0}}, b0};
    assign p01_d = {{H{1'b0}}, a0} * {{H{1'b0}}, b1};
    assign p10_d = {{H{1'b0}}, a1} * {{H{1'b0}}, b0};
    assign p11_d = {{H{1'b0}}, a1} * {{H{1'b0}}, b1};

    // Signed high words are the unsigned high word minus the other operand per negative source.
    always_comb begin
        ca_d = '0;
        cb_d = '0;
        if ((in_mode_e == MODE_MULXSU || in_mode_e == MODE_MULXSS) && in_src1[DATA_W-1])
            ca_d = in_src2;
        if (in_mode_e == MODE_MULXSS && in_src2[DATA_W-1])
            cb_d = in_src1;
    end

    assign mid_sum = {1'b0, p01} + {1'b0, p10};
    assign prod    = {{DATA_W{1'b0}}, p00}
                   + ({{(DATA_W-1){1'b0}}, mid_sum} << H)
                   + {p11, {DATA_W{1'b0}}};
    assign hi      = prod[PW-1:DATA_W];

    always_comb begin
        result_d = hi - ca - cb;
        case (mode1)
            MODE_MUL:    result_d = prod[DATA_W-1:0];
            MODE_MULXUU: result_d = hi;
            default:     result_d = hi - ca - cb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1         <= 1'b0;
            mode1      <= MODE_MUL;
            tag1       <= '0;
            p00        <= '0;
            p01        <= '0;
            p10        <= '0;
            p11        <= '0;
            ca         <= '0;
            cb         <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (en) begin
                mode1      <= in_mode_e;
                tag1       <= in_tag;
                p00        <= p00_d;
                p01        <= p01_d;
                p10        <= p10_d;
                p11        <= p11_d;
                ca         <= ca_d;
                cb         <= cb_d;
                out_result <= result_d;
                out_tag    <= tag1;
            end
            // Kill clears both valid bits even while stalled; data registers are don't-care then.
            if (kill) begin
                v1        <= 1'b0;
                out_valid <= 1'b0;
            end else if (en) begin
                v1        <= in_valid;
                out_valid <= v1;
            end
        end
    end
endmodule

// File: tb/tb_nios2_mult_cell_pipe.sv
// Bench for nios2_mult_cell_pipe: vector table, back-pressure and kill sequences, and a
// randomized run scored against a plain-arithmetic product model.
module tb_nios2_mult_cell_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, kill, out_valid, out_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;

    logic        in_valid_16, in_ready_16, kill_16, out_valid_16, out_ready_16;
    logic [1:0]  in_mode_16;
    logic [15:0] in_src1_16, in_src2_16, out_result_16;
    logic [4:0]  in_tag_16, out_tag_16;

    nios2_mult_cell_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    nios2_mult_cell_pipe #(.DATA_W(16), .TAG_W(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .in_mode(in_mode_16), .in_src1(in_src1_16), .in_src2(in_src2_16), .in_tag(in_tag_16),
        .kill(kill_16), .out_valid(out_valid_16), .out_ready(out_ready_16),
        .out_result(out_result_16), .out_tag(out_tag_16)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   delivered = 0;
    logic accepted;
    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: true signed/unsigned product of the extended operands, then pick the word.
    function automatic logic [31:0] ref32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] sa, sb, pr;
        sa = $signed({{34{a[31] & m[1]}}, a});
        sb = $signed({{34{b[31] & (m == 2'b11)}}, b});
        pr = sa * sb;
        return (m == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Called at the falling edge with inputs already driven; scores the coming rising edge.
    task automatic step();
        exp_t e;
        #1;
        accepted = 1'b0;
        if (out_valid && out_ready) begin
            delivered++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got tag %0d want none", out_tag);
            end else begin
                e = q.pop_front();
                chk("sb_result", 64'(out_result), 64'(e.res));
                chk("sb_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        if (kill) begin
            q.delete();
        end else if (!reset && in_valid && in_ready) begin
            accepted = 1'b1;
            q.push_back('{res: ref32(in_mode, in_src1, in_src2), tag: in_tag});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t tbl16[3];
        int   sent, stall_left, d0;
        logic first;

        tbl[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
        tbl[1] = '{2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002};
        tbl[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[5] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl16[0] = '{2'b11, 32'h8000, 32'h8000, 32'h4000};
        tbl16[1] = '{2'b10, 32'h8000, 32'h8000, 32'hC000};
        tbl16[2] = '{2'b00, 32'h8000, 32'h8000, 32'h0000};

        reset = 1'b1; kill = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 2'b00; in_src1 = 32'h1234_5678; in_src2 = 32'h9ABC_DEF0; in_tag = 5'd7;
        in_valid_16 = 1'b1; kill_16 = 1'b0; out_ready_16 = 1'b1;
        in_mode_16 = 2'b00; in_src1_16 = 16'h1234; in_src2_16 = 16'h5678; in_tag_16 = 5'd3;

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_out_result", 64'(out_result), 64'(0));
            chk("rst_out_tag", 64'(out_tag), 64'(0));
            chk("rst16_out_valid", 64'(out_valid_16), 64'(0));
        end
        reset = 1'b0;
        in_valid = 1'b0;
        in_valid_16 = 1'b0;
        #1 chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // Table vectors, one at a time: result appears after the edge following acceptance.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_mode = tbl[i].mode;
            in_src1 = tbl[i].a; in_src2 = tbl[i].b; in_tag = 5'(i + 1);
            #1 chk("vec_in_ready", 64'(in_ready), 64'(1));
            step();
            in_valid = 1'b0;
            chk("vec_early_valid", 64'(out_valid), 64'(0));
            step();
            chk("vec_out_valid", 64'(out_valid), 64'(1));
            chk("vec_result", 64'(out_result), 64'(tbl[i].exp));
            chk("vec_tag", 64'(out_tag), 64'(i + 1));
            step();
        end

        for (int i = 0; i < 3; i++) begin
            in_valid_16 = 1'b1; in_mode_16 = tbl16[i].mode;
            in_src1_16 = tbl16[i].a[15:0]; in_src2_16 = tbl16[i].b[15:0]; in_tag_16 = 5'(i + 10);
            @(posedge clk); @(negedge clk);
            in_valid_16 = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("w16_out_valid", 64'(out_valid_16), 64'(1));
            chk("w16_result", 64'(out_result_16), 64'(tbl16[i].exp[15:0]));
            chk("w16_tag", 64'(out_tag_16), 64'(i + 10));
            @(posedge clk); @(negedge clk);
        end

        // Back-pressure: six back-to-back ops, consumer stalls three cycles on the first result.
        sent = 0; stall_left = 0; first = 1'b1; d0 = delivered;
        for (int c = 0; c < 60; c++) begin
            if (sent == 6 && q.size() == 0 && !out_valid) break;
            if (first && out_valid) begin
                stall_left = 3;
                first = 1'b0;
            end
            out_ready = (stall_left == 0);
            in_valid = (sent < 6);
            in_tag = 5'(sent + 1);
            in_mode = 2'(sent % 4);
            in_src1 = pick();
            in_src2 = pick();
            if (stall_left > 0) begin
                #1;
                chk("bp_in_ready_low", 64'(in_ready), 64'(0));
                chk("bp_hold_valid", 64'(out_valid), 64'(1));
                stall_left--;
            end
            step();
            if (accepted) sent++;
        end
        chk("bp_sent", 64'(sent), 64'(6));
        chk("bp_delivered", 64'(delivered - d0), 64'(6));
        chk("bp_queue_empty", 64'(q.size()), 64'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Kill while stalled: tags 1 and 2 flushed, tag 3 offered with kill.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00;
        in_src1 = 32'd6; in_src2 = 32'd7;
        for (int t = 1; t <= 3; t++) begin
            in_tag = 5'(t);
            kill = (t == 3);
            step();
        end
        kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("kill_valid_c1", 64'(out_valid), 64'(0));
        step();
        chk("kill_valid_c2", 64'(out_valid), 64'(0));
        in_valid = 1'b1; in_tag = 5'd4; in_mode = 2'b11; in_src1 = 32'hFFFF_FFFD; in_src2 = 32'd5;
        step();
        in_valid = 1'b0;
        step();
        chk("post_kill_valid", 64'(out_valid), 64'(1));
        chk("post_kill_tag", 64'(out_tag), 64'(4));
        chk("post_kill_result", 64'(out_result), 64'(32'hFFFF_FFFF));
        step();

        // Kill while flowing: tag 1 is handed over in the kill cycle, tags 2 and 3 vanish.
        d0 = delivered;
        in_valid = 1'b1; in_mode = 2'b01; in_src1 = 32'hDEAD_BEEF; in_src2 = 32'hCAFE_F00D;
        for (int t = 1; t <= 3; t++) begin
            in_tag = 5'(t);
            kill = (t == 3);
            step();
        end
        kill = 1'b0; in_valid = 1'b0;
        chk("killflow_valid_c1", 64'(out_valid), 64'(0));
        step();
        chk("killflow_valid_c2", 64'(out_valid), 64'(0));
        step();
        chk("killflow_delivered", 64'(delivered - d0), 64'(1));

        // Randomized traffic with random stalls and occasional kills.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            kill = ($urandom_range(0, 24) == 0);
            in_mode = 2'($urandom_range(0, 3));
            in_src1 = pick();
            in_src2 = pick();
            in_tag = 5'($urandom_range(0, 31));
            step();
        end
        in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && (q.size() != 0 || out_valid); c++) step();
        chk("rand_drained", 64'(q.size()), 64'(0));
        chk("rand_idle_valid", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
